time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
// - Mode/setting controller in front of the Time counter and the alarm time register.
// - Turns debounced Set/Minute/Hour button levels into single-cycle increment pulses, with hold-to-repeat.
// - Steers each pulse to the clock or the alarm target according to the current mode.
// - Drives the display blink enable and returns to RUN after a period with no button activity.
// PARAMETERS
// - HOLD_CYCLES    2500000  clocks a Min/Hour button must stay held before auto-repeat starts (0.5 s @ 5 MHz)
// - REPEAT_CYCLES  1000000  clocks between auto-repeat pulses while the button stays held (0.2 s @ 5 MHz)
// - TIMEOUT_S      10       seconds (i_Clk_1Hz_Pulse count) with no button activity before returning to RUN
// PORTS
// - i_Clk_5MHz           in   1  system clock
// - i_Reset_n            in   1  synchronous reset, active-low
// - i_Clk_1Hz_Pulse      in   1  one-cycle 1 Hz strobe
// - i_Set_Btn            in   1  debounced mode button, level
// - i_Min_Btn            in   1  debounced minute button, level
// - i_Hour_Btn           in   1  debounced hour button, level
// - o_Time_Minutes_Inc   out  1  one-cycle pulse to Time i_Minutes_Inc
// - o_Time_Hours_Inc     out  1  one-cycle pulse to Time i_Hours_Inc
// - o_Alarm_Minutes_Inc  out  1  one-cycle pulse to alarm register, minutes
// - o_Alarm_Hours_Inc    out  1  one-cycle pulse to alarm register, hours
// - o_Mode               out  2  00=RUN, 01=SET_TIME, 10=SET_ALARM
// - o_Display_On         out  1  display enable: 1 in RUN; toggles in set modes
// BEHAVIOUR
// - Reset (i_Reset_n=0 at a clock edge): state=RUN, all pulse outputs 0, o_Display_On=1, timers and edge registers cleared. Reset has priority over all other inputs.
// - Edge detection: each button has a registered previous value; a rise is btn & ~prev. prev resets to 0, so a button held through reset release gives one rise.
// - FSM: RUN -(Set rise)-> SET_TIME -(Set rise)-> SET_ALARM -(Set rise)-> RUN.
// - Timeout exits either set mode to RUN. In RUN, Min/Hour buttons are ignored and produce no pulses.
// - Pulse latency: an output pulse is asserted in the clock cycle after the button rise is sampled (1-cycle registered). Each pulse is exactly 1 cycle wide.
// - Target: SET_TIME drives o_Time_*; SET_ALARM drives o_Alarm_*. At most one of the four pulse outputs is high in any cycle.
// - Hold/repeat, per active button:
//   - A hold counter starts at the rise.
//   - After HOLD_CYCLES of continuous hold, one pulse is issued, then one more every REPEAT_CYCLES.
//   - Release clears the counter immediately; no pulse is issued on release.
// - Priority: Hour wins over Min.
//   - If both rise in the same cycle, only the hour pulse is issued.
//   - While Hour is held, Min is masked.
//   - Min is accepted again only after a fresh Min rise following Hour release.
// - Set rise in the same cycle as a Min/Hour rise: the mode changes and the Min/Hour event is dropped.
// - Timeout counter:
//   - Increments on i_Clk_1Hz_Pulse while in a set mode with no button held.
//   - Clears on any button rise, while any button is held, and on every mode change.
//   - Reaching TIMEOUT_S forces RUN on the next clock.
// - Display: in a set mode, o_Display_On toggles on each i_Clk_1Hz_Pulse and is forced to 1 for the cycle of any issued pulse. On entering RUN it is forced to 1.
// - Mode change while a button is held aborts that button's repeat; no pulse follows the change until a new rise.
// - Counter widths: $clog2 of the relevant max + 1. Counters saturate and never wrap.
// CONFIGURATION
// - TIME_SET_ALARM_EN defined: FSM as above, with three modes.
// - TIME_SET_ALARM_EN undefined:
//   - SET_ALARM does not exist; FSM is RUN <-> SET_TIME.
//   - o_Alarm_Minutes_Inc and o_Alarm_Hours_Inc are tied to 0; o_Mode never equals 10.
// TESTING (sim with HOLD_CYCLES=20, REPEAT_CYCLES=5, TIMEOUT_S=3)
// - Reset: hold i_Reset_n=0 with all buttons high -> o_Mode=00, o_Display_On=1, all pulses 0. Release -> one Set rise -> o_Mode=01.
// - Mode cycle: 3 Set presses from RUN -> o_Mode 01,10,00. With TIME_SET_ALARM_EN undefined, 2 presses -> 01,00.
// - Single press: in SET_TIME, Min held for 3 cycles -> exactly one o_Time_Minutes_Inc, 1 cycle after the rise; no o_Alarm_* activity.
// - Hold/repeat: in SET_ALARM, Hour held for 40 cycles -> pulses at rise+1, rise+21, +26, +31, +36: 5 o_Alarm_Hours_Inc total.
// - Simultaneous: Min and Hour rise in the same cycle in SET_TIME -> one o_Time_Hours_Inc only. After Hour release with Min still high -> no minute pulse.
// - Timeout: enter SET_TIME, no buttons, 3 x 1Hz pulses -> o_Mode=00 on the next cycle, o_Display_On=1. A button rise after 2 x 1Hz pulses restarts the count.

Source files
------------

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Mode/setting controller in front of the time counter and the alarm time
// register. It turns debounced Set/Minute/Hour button levels into one-cycle
// increment pulses, with hold-to-repeat. Each pulse goes to the clock or the
// alarm target according to the current mode. It also drives the display blink
// enable, and it returns to RUN after a period with no button activity.
//
// Optional feature macro: TIME_SET_ALARM_EN
//   defined   : three modes, RUN -> SET_TIME -> SET_ALARM -> RUN
//   undefined : two modes, RUN <-> SET_TIME; alarm pulse outputs are tied to 0
//
// Ports
//   i_Clk_5MHz           in   1  system clock
//   i_Reset_n            in   1  synchronous reset, active-low
//   i_Clk_1Hz_Pulse      in   1  one-cycle 1 Hz strobe
//   i_Set_Btn            in   1  debounced mode button (level)
//   i_Min_Btn            in   1  debounced minute button (level)
//   i_Hour_Btn           in   1  debounced hour button (level)
//   o_Time_Minutes_Inc   out  1  one-cycle pulse, time minutes increment
//   o_Time_Hours_Inc     out  1  one-cycle pulse, time hours increment
//   o_Alarm_Minutes_Inc  out  1  one-cycle pulse, alarm minutes increment
//   o_Alarm_Hours_Inc    out  1  one-cycle pulse, alarm hours increment
//   o_Mode               out  2  00=RUN, 01=SET_TIME, 10=SET_ALARM
//   o_Display_On         out  1  display enable (blinks in set modes)
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int HOLD_CYCLES   = 2500000,
    parameter int REPEAT_CYCLES = 1000000,
    parameter int TIMEOUT_S     = 10
) (
    input  logic       i_Clk_5MHz,
    input  logic       i_Reset_n,
    input  logic       i_Clk_1Hz_Pulse,
    input  logic       i_Set_Btn,
    input  logic       i_Min_Btn,
    input  logic       i_Hour_Btn,
    output logic       o_Time_Minutes_Inc,
    output logic       o_Time_Hours_Inc,
    output logic       o_Alarm_Minutes_Inc,
    output logic       o_Alarm_Hours_Inc,
    output logic [1:0] o_Mode,
    output logic       o_Display_On
);

    localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW     = $clog2(HR_MAX) + 1;
    localparam int TW     = $clog2(TIMEOUT_S) + 1;

    localparam logic [HW-1:0] HOLD_LIM    = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REPEAT_LIM  = HW'(REPEAT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_S);

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_SET_TIME  = 2'b01,
        ST_SET_ALARM = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        BTN_NONE = 2'b00,
        BTN_MIN  = 2'b01,
        BTN_HOUR = 2'b10
    } active_t;

    mode_t          state, next_state;
    active_t        active, active_d;
    logic [HW-1:0]  hold_cnt, hold_cnt_d, hold_inc;
    logic           repeating, repeating_d;
    logic [TW-1:0]  timeout_cnt;
    logic           set_prev, min_prev, hour_prev;
    logic           set_rise, min_rise, hour_rise;
    logic           mode_change, hold_due;
    logic           fire_min, fire_hour;
    logic           min_pulse_q, hour_pulse_q;
    logic           display_q;
    logic           alarm_tgt;

    assign set_rise    = i_Set_Btn  & ~set_prev;
    assign min_rise    = i_Min_Btn  & ~min_prev;
    assign hour_rise   = i_Hour_Btn & ~hour_prev;
    assign mode_change = (next_state != state);

    // State register: holds the current mode.
    always_ff @(posedge i_Clk_5MHz) begin
        if (!i_Reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The timeout wins over a Set press, and an illegal
    // encoding falls back to RUN.
    always_comb begin
        next_state = state;
        if (state != ST_RUN && timeout_cnt >= TIMEOUT_LIM) begin
            next_state = ST_RUN;
        end else if (set_rise) begin
            case (state)
                ST_RUN:       next_state = ST_SET_TIME;
`ifdef TIME_SET_ALARM_EN
                ST_SET_TIME:  next_state = ST_SET_ALARM;
`else
                ST_SET_TIME:  next_state = ST_RUN;
`endif
                ST_SET_ALARM: next_state = ST_RUN;
                default:      next_state = ST_RUN;
            endcase
        end
    end

    // Button tracking: choose the active button and run its hold/repeat timer.
    // A mode change, or being in RUN, drops any pending repeat. The same
    // happens when a Min/Hour rise shares a cycle with a Set rise. Hour takes
    // priority. A Min rise is ignored while Hour is held, so after Hour is
    // released Min needs a fresh press.
    always_comb begin
        active_d    = active;
        hold_cnt_d  = hold_cnt;
        repeating_d = repeating;
        fire_min    = 1'b0;
        fire_hour   = 1'b0;
        hold_inc    = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
        hold_due    = repeating ? (hold_inc == REPEAT_LIM) : (hold_inc == HOLD_LIM);

        if (state == ST_RUN || mode_change) begin
            active_d    = BTN_NONE;
            hold_cnt_d  = '0;
            repeating_d = 1'b0;
        end else if (hour_rise) begin
            active_d    = BTN_HOUR;
            hold_cnt_d  = '0;
            repeating_d = 1'b0;
            fire_hour   = 1'b1;
        end else if (active == BTN_HOUR) begin
            if (!i_Hour_Btn) begin
                active_d    = BTN_NONE;
                hold_cnt_d  = '0;
                repeating_d = 1'b0;
            end else if (hold_due) begin
                hold_cnt_d  = '0;
                repeating_d = 1'b1;
                fire_hour   = 1'b1;
            end else begin
                hold_cnt_d  = hold_inc;
            end
        end else if (min_rise && !i_Hour_Btn) begin
            active_d    = BTN_MIN;
            hold_cnt_d  = '0;
            repeating_d = 1'b0;
            fire_min    = 1'b1;
        end else if (active == BTN_MIN) begin
            if (!i_Min_Btn) begin
                active_d    = BTN_NONE;
                hold_cnt_d  = '0;
                repeating_d = 1'b0;
            end else if (hold_due) begin
                hold_cnt_d  = '0;
                repeating_d = 1'b1;
                fire_min    = 1'b1;
            end else begin
                hold_cnt_d  = hold_inc;
            end
        end
    end

    // Registered state: edge history, hold timer, the one-cycle pulses, the
    // saturating timeout counter and the blink register.
    always_ff @(posedge i_Clk_5MHz) begin
        if (!i_Reset_n) begin
            set_prev     <= 1'b0;
            min_prev     <= 1'b0;
            hour_prev    <= 1'b0;
            active       <= BTN_NONE;
            hold_cnt     <= '0;
            repeating    <= 1'b0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            timeout_cnt  <= '0;
            display_q    <= 1'b1;
        end else begin
            set_prev     <= i_Set_Btn;
            min_prev     <= i_Min_Btn;
            hour_prev    <= i_Hour_Btn;
            active       <= active_d;
            hold_cnt     <= hold_cnt_d;
            repeating    <= repeating_d;
            min_pulse_q  <= fire_min;
            hour_pulse_q <= fire_hour;

            if (state == ST_RUN || mode_change ||
                i_Set_Btn || i_Min_Btn || i_Hour_Btn) begin
                timeout_cnt <= '0;
            end else if (i_Clk_1Hz_Pulse && timeout_cnt != TIMEOUT_LIM) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if (next_state == ST_RUN || fire_min || fire_hour) begin
                display_q <= 1'b1;
            end else if (i_Clk_1Hz_Pulse) begin
                display_q <= ~display_q;
            end
        end
    end

`ifdef TIME_SET_ALARM_EN
    logic alarm_tgt_q;

    // The pulse target is latched together with the pulse. A pulse is only
    // ever fired when the mode is not changing in that cycle.
    always_ff @(posedge i_Clk_5MHz) begin
        if (!i_Reset_n) begin
            alarm_tgt_q <= 1'b0;
        end else begin
            alarm_tgt_q <= (state == ST_SET_ALARM);
        end
    end
    assign alarm_tgt = alarm_tgt_q;
`else
    assign alarm_tgt = 1'b0;
`endif

    // Output decode: steer the registered pulses to their target.
    always_comb begin
        o_Mode             = state;
        o_Display_On       = display_q;
        o_Time_Minutes_Inc = min_pulse_q  & ~alarm_tgt;
        o_Time_Hours_Inc   = hour_pulse_q & ~alarm_tgt;
`ifdef TIME_SET_ALARM_EN
        o_Alarm_Minutes_Inc = min_pulse_q  & alarm_tgt;
        o_Alarm_Hours_Inc   = hour_pulse_q & alarm_tgt;
`else
        o_Alarm_Minutes_Inc = 1'b0;
        o_Alarm_Hours_Inc   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Directed bench for time_set_ctrl, using HOLD_CYCLES=20, REPEAT_CYCLES=5 and
// TIMEOUT_S=3. Inputs change 1 time unit after a rising edge. Outputs are
// sampled at that same point, so each tick() shows the effect of one edge.
// The pulse vector is {TimeMin, TimeHour, AlarmMin, AlarmHour}.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       p1hz;
    logic       set_btn, min_btn, hour_btn;
    logic       time_min, time_hour, alarm_min, alarm_hour;
    logic [1:0] mode;
    logic       display_on;
    logic [3:0] pulse_vec;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [1:0] M_RUN   = 2'b00;
    localparam logic [1:0] M_TIME  = 2'b01;
    localparam logic [1:0] M_ALARM = 2'b10;

    assign pulse_vec = {time_min, time_hour, alarm_min, alarm_hour};

    always #5 clk = ~clk;

    time_set_ctrl #(
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(5),
        .TIMEOUT_S    (3)
    ) dut (
        .i_Clk_5MHz         (clk),
        .i_Reset_n          (reset_n),
        .i_Clk_1Hz_Pulse    (p1hz),
        .i_Set_Btn          (set_btn),
        .i_Min_Btn          (min_btn),
        .i_Hour_Btn         (hour_btn),
        .o_Time_Minutes_Inc (time_min),
        .o_Time_Hours_Inc   (time_hour),
        .o_Alarm_Minutes_Inc(alarm_min),
        .o_Alarm_Hours_Inc  (alarm_hour),
        .o_Mode             (mode),
        .o_Display_On       (display_on)
    );

    // Advance one clock. Return just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        p1hz     = 1'b0;
        set_btn  = 1'b0;
        min_btn  = 1'b0;
        hour_btn = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic press_set();
        set_btn = 1'b1;
        tick();
        set_btn = 1'b0;
        tick();
    endtask

    task automatic one_hz();
        p1hz = 1'b1;
        tick();
        p1hz = 1'b0;
        tick();
    endtask

    // Reset has priority while all buttons are high. Releasing reset yields
    // one Set rise, and the Min/Hour rises in that same cycle are dropped.
    task automatic test_reset();
        reset_n  = 1'b0;
        p1hz     = 1'b0;
        set_btn  = 1'b1;
        min_btn  = 1'b1;
        hour_btn = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (mode !== M_RUN) begin
            n_fails++; $display("[TB] FAIL reset_mode: got %b, expected %b", mode, M_RUN);
        end
        n_checks++;
        if (display_on !== 1'b1) begin
            n_fails++; $display("[TB] FAIL reset_display: got %b, expected 1", display_on);
        end
        n_checks++;
        if (pulse_vec !== 4'b0000) begin
            n_fails++; $display("[TB] FAIL reset_pulses: got %b, expected 0000", pulse_vec);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (mode !== M_TIME) begin
            n_fails++; $display("[TB] FAIL reset_release_mode: got %b, expected %b", mode, M_TIME);
        end
        n_checks++;
        if (pulse_vec !== 4'b0000) begin
            n_fails++; $display("[TB] FAIL reset_release_pulses: got %b, expected 0000", pulse_vec);
        end
        tick();
        n_checks++;
        if (pulse_vec !== 4'b0000 || mode !== M_TIME) begin
            n_fails++; $display("[TB] FAIL reset_release_hold: got pulses %b mode %b, expected 0000 %b",
                                pulse_vec, mode, M_TIME);
        end
        set_btn  = 1'b0;
        min_btn  = 1'b0;
        hour_btn = 1'b0;
        tick();
    endtask

    task automatic test_mode_cycle();
        apply_reset();
        press_set();
        n_checks++;
        if (mode !== M_TIME) begin
            n_fails++; $display("[TB] FAIL mode_press1: got %b, expected %b", mode, M_TIME);
        end
        press_set();
`ifdef TIME_SET_ALARM_EN
        n_checks++;
        if (mode !== M_ALARM) begin
            n_fails++; $display("[TB] FAIL mode_press2: got %b, expected %b", mode, M_ALARM);
        end
        press_set();
        n_checks++;
        if (mode !== M_RUN) begin
            n_fails++; $display("[TB] FAIL mode_press3: got %b, expected %b", mode, M_RUN);
        end
`else
        n_checks++;
        if (mode !== M_RUN) begin
            n_fails++; $display("[TB] FAIL mode_press2: got %b, expected %b", mode, M_RUN);
        end
`endif
    endtask

    task automatic test_run_ignore();
        apply_reset();
        min_btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) hour_btn = 1'b1;
            n_checks++;
            if (pulse_vec !== 4'b0000) begin
                n_fails++; $display("[TB] FAIL run_ignore k=%0d: got %b, expected 0000", k, pulse_vec);
            end
        end
        min_btn  = 1'b0;
        hour_btn = 1'b0;
        tick();
        n_checks++;
        if (mode !== M_RUN) begin
            n_fails++; $display("[TB] FAIL run_ignore_mode: got %b, expected %b", mode, M_RUN);
        end
    endtask

    // Min is held for 3 sampled edges and gives one pulse, on the edge after the rise.
    task automatic test_single_press();
        apply_reset();
        press_set();
        min_btn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 3) min_btn = 1'b0;
            n_checks++;
            if (pulse_vec !== ((k == 1) ? 4'b1000 : 4'b0000)) begin
                n_fails++; $display("[TB] FAIL single_press k=%0d: got %b, expected %b",
                                    k, pulse_vec, (k == 1) ? 4'b1000 : 4'b0000);
            end
        end
    endtask

    // Hour is held for 40 sampled edges. Pulses are expected at rise+1, +21,
    // +26, +31 and +36.
    task automatic test_hold_repeat();
        logic [3:0] exp_bit;
        logic [3:0] exp_vec;
        int         count;
        count = 0;
        apply_reset();
        press_set();
`ifdef TIME_SET_ALARM_EN
        press_set();
        exp_bit = 4'b0001;
`else
        exp_bit = 4'b0100;
`endif
        hour_btn = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            exp_vec = (k == 1 || k == 21 || k == 26 || k == 31 || k == 36) ? exp_bit : 4'b0000;
            if (pulse_vec != 4'b0000) count++;
            n_checks++;
            if (pulse_vec !== exp_vec) begin
                n_fails++; $display("[TB] FAIL hold_repeat k=%0d: got %b, expected %b", k, pulse_vec, exp_vec);
            end
            if (k == 40) hour_btn = 1'b0;
        end
        n_checks++;
        if (count != 5) begin
            n_fails++; $display("[TB] FAIL hold_repeat_count: got %0d, expected 5", count);
        end
    endtask

    // Min and Hour rise together and only the hour pulse is issued. Min, still
    // held after Hour is released, must not produce a pulse.
    task automatic test_simultaneous();
        apply_reset();
        press_set();
        min_btn  = 1'b1;
        hour_btn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_checks++;
            if (pulse_vec !== ((k == 1) ? 4'b0100 : 4'b0000)) begin
                n_fails++; $display("[TB] FAIL simultaneous k=%0d: got %b, expected %b",
                                    k, pulse_vec, (k == 1) ? 4'b0100 : 4'b0000);
            end
            if (k == 4) hour_btn = 1'b0;
        end
        min_btn = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        press_set();
        p1hz = 1'b1;
        tick();
        p1hz = 1'b0;
        n_checks++;
        if (display_on !== 1'b0) begin
            n_fails++; $display("[TB] FAIL blink_toggle: got %b, expected 0", display_on);
        end
        tick();
        one_hz();
        p1hz = 1'b1;
        tick();
        p1hz = 1'b0;
        n_checks++;
        if (mode !== M_TIME) begin
            n_fails++; $display("[TB] FAIL timeout_early: got %b, expected %b", mode, M_TIME);
        end
        tick();
        n_checks++;
        if (mode !== M_RUN) begin
            n_fails++; $display("[TB] FAIL timeout_exit: got %b, expected %b", mode, M_RUN);
        end
        n_checks++;
        if (display_on !== 1'b1) begin
            n_fails++; $display("[TB] FAIL timeout_display: got %b, expected 1", display_on);
        end

        // A button press after two strobes restarts the count.
        apply_reset();
        press_set();
        one_hz();
        one_hz();
        min_btn = 1'b1;
        tick();
        min_btn = 1'b0;
        tick();
        one_hz();
        one_hz();
        n_checks++;
        if (mode !== M_TIME) begin
            n_fails++; $display("[TB] FAIL timeout_restart: got %b, expected %b", mode, M_TIME);
        end
        p1hz = 1'b1;
        tick();
        p1hz = 1'b0;
        tick();
        n_checks++;
        if (mode !== M_RUN) begin
            n_fails++; $display("[TB] FAIL timeout_restart_exit: got %b, expected %b", mode, M_RUN);
        end
    endtask

    // A mode change while Min is held cancels its repeat.
    task automatic test_mode_abort();
        apply_reset();
        press_set();
        min_btn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (pulse_vec !== ((k == 1) ? 4'b1000 : 4'b0000)) begin
                n_fails++; $display("[TB] FAIL abort_pre k=%0d: got %b, expected %b",
                                    k, pulse_vec, (k == 1) ? 4'b1000 : 4'b0000);
            end
        end
        set_btn = 1'b1;
        tick();
        set_btn = 1'b0;
        n_checks++;
`ifdef TIME_SET_ALARM_EN
        if (mode !== M_ALARM) begin
            n_fails++; $display("[TB] FAIL abort_mode: got %b, expected %b", mode, M_ALARM);
        end
`else
        if (mode !== M_RUN) begin
            n_fails++; $display("[TB] FAIL abort_mode: got %b, expected %b", mode, M_RUN);
        end
`endif
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_checks++;
            if (pulse_vec !== 4'b0000) begin
                n_fails++; $display("[TB] FAIL abort_post k=%0d: got %b, expected 0000", k, pulse_vec);
            end
        end
        min_btn = 1'b0;
        tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        p1hz     = 1'b0;
        set_btn  = 1'b0;
        min_btn  = 1'b0;
        hour_btn = 1'b0;
        test_reset();
        test_mode_cycle();
        test_run_ignore();
        test_single_press();
        test_hold_repeat();
        test_simultaneous();
        test_timeout();
        test_mode_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
